// File: rtl/gpio_v2_pkg.sv
// Shared constants for the second-generation Wishbone GPIO: register indices,
// interrupt mode encodings and the byte-lane helper.
package gpio_v2_pkg;

    localparam int unsigned WB_ADR_W = 6;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned DBDIV_W  = 16;

    localparam logic [3:0] GPIO_IN      = 4'd0;
    localparam logic [3:0] GPIO_OUT     = 4'd1;
    localparam logic [3:0] GPIO_OE      = 4'd2;
    localparam logic [3:0] GPIO_OUT_SET = 4'd3;
    localparam logic [3:0] GPIO_OUT_CLR = 4'd4;
    localparam logic [3:0] GPIO_OUT_TGL = 4'd5;
    localparam logic [3:0] GPIO_IE      = 4'd6;
    localparam logic [3:0] GPIO_IS      = 4'd7;
    localparam logic [3:0] GPIO_ITYPE   = 4'd8;
    localparam logic [3:0] GPIO_IPOL    = 4'd9;
    localparam logic [3:0] GPIO_IBOTH   = 4'd10;
    localparam logic [3:0] GPIO_DBEN    = 4'd11;
    localparam logic [3:0] GPIO_DBDIV   = 4'd12;
    localparam logic [3:0] GPIO_IO_SEL  = 4'd13;

    localparam logic ITYPE_EDGE  = 1'b0;
    localparam logic ITYPE_LEVEL = 1'b1;
    localparam logic IPOL_HIGH   = 1'b0;
    localparam logic IPOL_LOW    = 1'b1;
    localparam logic IBOTH_ON    = 1'b1;

    function automatic logic [WB_DAT_W-1:0] lane_mask(input logic [3:0] sel);
        logic [WB_DAT_W-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            m[8*k +: 8] = {8{sel[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_v2_if.sv
// Wishbone slave bus bundle for the GPIO block; clock and reset stay separate.
interface gpio_v2_if;
    import gpio_v2_pkg::*;

    logic                wb_cyc_i;
    logic                wb_stb_i;
    logic                wb_we_i;
    logic [WB_ADR_W-1:0] wb_adr_i;
    logic [WB_DAT_W-1:0] wb_dat_i;
    logic [3:0]          wb_sel_i;
    logic [WB_DAT_W-1:0] wb_dat_o;
    logic                wb_ack_o;
    logic                wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/gpio_v2_debounce.sv
// One pin's debounce filter: the filtered value follows the synchronised input
// only after it has differed for 2^DB_CNT_W-1 prescaler ticks.
module gpio_debounce #(
    parameter int unsigned DB_CNT_W = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic s,
    input  logic tick,
    input  logic en,
    output logic filt
);
    localparam logic [DB_CNT_W-1:0] CNT_LAST = {DB_CNT_W{1'b1}} - 1'b1;

    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic                filt_q, filt_d;

    // While disabled the stored value tracks s so re-enabling causes no false edge.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (!en) begin
            cnt_d  = '0;
            filt_d = s;
        end else if (s == filt_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                filt_d = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = en ? filt_q : s;

endmodule

// File: rtl/gpio_v2_top.sv
// Wishbone GPIO with atomic set/clear/toggle, per-pin edge/level interrupts,
// per-pin debounce and a shared-pin ownership mask.
module gpio_v2_top
    import gpio_v2_pkg::*;
#(
    parameter int unsigned NO_OF_GPIO_PINS   = 32,
    parameter int unsigned NO_OF_SHARED_PINS = 15,
    parameter int unsigned DB_CNT_W          = 3
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    gpio_v2_if.slave                     wb,
    input  logic [NO_OF_GPIO_PINS-1:0]   i_gpio,
    output logic [NO_OF_GPIO_PINS-1:0]   o_gpio,
    output logic [NO_OF_GPIO_PINS-1:0]   en_gpio,
    output logic [NO_OF_SHARED_PINS-1:0] io_sel,
    output logic                         wb_inta_o
);
    localparam int unsigned N = NO_OF_GPIO_PINS;
    localparam int unsigned S = NO_OF_SHARED_PINS;

    logic                acc, commit, ack_q;
    logic [3:0]          idx;
    logic [15:0]         wr_sel;
    logic [WB_DAT_W-1:0] lane_m, wdm, rdata;
    logic [N-1:0]        wm_n, wd_n;
    logic [S-1:0]        wm_s, wd_s;
    logic                unused_adr;

    logic [N-1:0] out_q, out_d, oe_q, oe_d, ie_q, ie_d, is_q, is_d;
    logic [N-1:0] itype_q, itype_d, ipol_q, ipol_d, iboth_q, iboth_d, dben_q, dben_d;
    logic [S-1:0] iosel_q, iosel_d;
    logic [DBDIV_W-1:0] dbdiv_q, dbdiv_d, pre_q, pre_d;
    logic         tick;

    logic [N-1:0] sync1_q, sync2_q, filt, prev_q, hit, qual, iosel_n, w1c;

    assign acc        = wb.wb_cyc_i & wb.wb_stb_i;
    assign commit     = acc & ~ack_q & wb.wb_we_i;
    assign idx        = wb.wb_adr_i[5:2];
    assign unused_adr = ^wb.wb_adr_i[1:0];
    assign wr_sel     = commit ? (16'd1 << idx) : '0;
    assign lane_m     = lane_mask(wb.wb_sel_i);
    assign wdm        = wb.wb_dat_i & lane_m;
    assign wm_n       = lane_m[N-1:0];
    assign wd_n       = wdm[N-1:0];
    assign wm_s       = lane_m[S-1:0];
    assign wd_s       = wdm[S-1:0];

    always_comb begin
        out_d   = out_q;
        oe_d    = wr_sel[GPIO_OE]    ? (oe_q    & ~wm_n) | wd_n : oe_q;
        ie_d    = wr_sel[GPIO_IE]    ? (ie_q    & ~wm_n) | wd_n : ie_q;
        itype_d = wr_sel[GPIO_ITYPE] ? (itype_q & ~wm_n) | wd_n : itype_q;
        ipol_d  = wr_sel[GPIO_IPOL]  ? (ipol_q  & ~wm_n) | wd_n : ipol_q;
        iboth_d = wr_sel[GPIO_IBOTH] ? (iboth_q & ~wm_n) | wd_n : iboth_q;
        dben_d  = wr_sel[GPIO_DBEN]  ? (dben_q  & ~wm_n) | wd_n : dben_q;
        iosel_d = wr_sel[GPIO_IO_SEL] ? (iosel_q & ~wm_s) | wd_s : iosel_q;
        dbdiv_d = wr_sel[GPIO_DBDIV] ? (dbdiv_q & ~lane_m[DBDIV_W-1:0]) | wdm[DBDIV_W-1:0]
                                     : dbdiv_q;
        if (wr_sel[GPIO_OUT])     out_d = (out_q & ~wm_n) | wd_n;
        if (wr_sel[GPIO_OUT_SET]) out_d = out_q | wd_n;
        if (wr_sel[GPIO_OUT_CLR]) out_d = out_q & ~wd_n;
        if (wr_sel[GPIO_OUT_TGL]) out_d = out_q ^ wd_n;
    end

    // Prescaler: tick every DBDIV+1 cycles, restarted by any DBDIV write.
    assign tick  = (pre_q == dbdiv_q);
    assign pre_d = (wr_sel[GPIO_DBDIV] || tick) ? '0 : pre_q + 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_db
        gpio_debounce #(.DB_CNT_W(DB_CNT_W)) u_db (
            .clk_i (wb_clk_i),
            .rst_i (wb_rst_i),
            .s     (sync2_q[i]),
            .tick  (tick),
            .en    (dben_q[i]),
            .filt  (filt[i])
        );
    end

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (itype_q[i] == ITYPE_LEVEL) begin
                hit[i] = (ipol_q[i] == IPOL_LOW) ? ~filt[i] : filt[i];
            end else if (iboth_q[i] == IBOTH_ON) begin
                hit[i] = filt[i] ^ prev_q[i];
            end else if (ipol_q[i] == IPOL_LOW) begin
                hit[i] = ~filt[i] & prev_q[i];
            end else begin
                hit[i] = filt[i] & ~prev_q[i];
            end
        end
    end

    assign iosel_n = N'(iosel_q);
    assign qual    = hit & ie_q & ~iosel_n;
    assign w1c     = wr_sel[GPIO_IS] ? wd_n : '0;
    // Set has priority over a same-cycle clear.
    assign is_d    = (is_q & ~w1c) | qual;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q   <= 1'b0;
            out_q   <= '0;
            oe_q    <= '1;
            ie_q    <= '0;
            is_q    <= '0;
            itype_q <= '0;
            ipol_q  <= '0;
            iboth_q <= '0;
            dben_q  <= '0;
            dbdiv_q <= '0;
            iosel_q <= '1;
            pre_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            ack_q   <= acc & ~ack_q;
            out_q   <= out_d;
            oe_q    <= oe_d;
            ie_q    <= ie_d;
            is_q    <= is_d;
            itype_q <= itype_d;
            ipol_q  <= ipol_d;
            iboth_q <= iboth_d;
            dben_q  <= dben_d;
            dbdiv_q <= dbdiv_d;
            iosel_q <= iosel_d;
            pre_q   <= pre_d;
            sync1_q <= i_gpio;
            sync2_q <= sync1_q;
            prev_q  <= filt;
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            GPIO_IN:                                          rdata = 32'(filt);
            GPIO_OUT, GPIO_OUT_SET, GPIO_OUT_CLR, GPIO_OUT_TGL: rdata = 32'(out_q);
            GPIO_OE:                                          rdata = 32'(oe_q);
            GPIO_IE:                                          rdata = 32'(ie_q);
            GPIO_IS:                                          rdata = 32'(is_q);
            GPIO_ITYPE:                                       rdata = 32'(itype_q);
            GPIO_IPOL:                                        rdata = 32'(ipol_q);
            GPIO_IBOTH:                                       rdata = 32'(iboth_q);
            GPIO_DBEN:                                        rdata = 32'(dben_q);
            GPIO_DBDIV:                                       rdata = 32'(dbdiv_q);
            GPIO_IO_SEL:                                      rdata = 32'(iosel_q);
            default:                                          rdata = '0;
        endcase
    end

    assign wb.wb_dat_o = ack_q ? rdata : '0;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = 1'b0;
    assign o_gpio      = out_q;
    assign en_gpio     = oe_q;
    assign io_sel      = iosel_q;
    assign wb_inta_o   = |(is_q & ie_q);

endmodule

// File: tb/tb_gpio_v2_top.sv
// Scoreboard bench for gpio_v2_top: stimulus queues expectations, a negedge
// monitor pops and compares read data and pin-level checks.
module tb_gpio_v2_top;
    import gpio_v2_pkg::*;

    typedef enum int {K_OGPIO, K_EN, K_IOSEL, K_INTA, K_ACK, K_VAL} kind_e;
    typedef struct { logic chk; logic [31:0] exp; string name; } rd_t;
    typedef struct { kind_e kind; logic [31:0] exp; logic [31:0] act; string name; } pc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_gpio, o_gpio, en_gpio;
    logic [14:0] io_sel;
    logic        inta;
    int          total = 0;
    int          bad   = 0;
    rd_t         rq[$];
    pc_t         cq[$];
    logic [31:0] rst_exp [16];

    always #5 clk = ~clk;

    gpio_v2_if wbif();

    gpio_v2_top #(.NO_OF_GPIO_PINS(32), .NO_OF_SHARED_PINS(15), .DB_CNT_W(3)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb        (wbif),
        .i_gpio    (i_gpio),
        .o_gpio    (o_gpio),
        .en_gpio   (en_gpio),
        .io_sel    (io_sel),
        .wb_inta_o (inta)
    );

    always @(negedge clk) begin : mon
        rd_t         r;
        pc_t         c;
        logic [31:0] a;
        if (wbif.wb_ack_o) begin
            if (rq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_ack got=1 exp=0");
            end else begin
                r = rq.pop_front();
                if (r.chk) begin
                    total++;
                    if (wbif.wb_dat_o !== r.exp) begin
                        bad++;
                        $display("FAIL %s got=%h exp=%h", r.name, wbif.wb_dat_o, r.exp);
                    end
                end
            end
        end
        while (cq.size() > 0) begin
            c = cq.pop_front();
            case (c.kind)
                K_OGPIO: a = o_gpio;
                K_EN:    a = en_gpio;
                K_IOSEL: a = 32'(io_sel);
                K_INTA:  a = 32'(inta);
                K_ACK:   a = 32'(wbif.wb_ack_o);
                default: a = c.act;
            endcase
            total++;
            if (a !== c.exp) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", c.name, a, c.exp);
            end
        end
    end

    task automatic pchk(input kind_e k, input logic [31:0] e, input string nm);
        cq.push_back('{kind: k, exp: e, act: 32'd0, name: nm});
    endtask

    task automatic access(input logic we, input logic [3:0] idx, input logic [31:0] d,
                          input logic [3:0] sel, input logic c, input logic [31:0] e,
                          input string nm);
        int n;
        @(posedge clk);
        #1;
        wbif.wb_cyc_i = 1'b1;
        wbif.wb_stb_i = 1'b1;
        wbif.wb_we_i  = we;
        wbif.wb_adr_i = {idx, 2'b00};
        wbif.wb_dat_i = d;
        wbif.wb_sel_i = sel;
        rq.push_back('{chk: c, exp: e, name: nm});
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wbif.wb_ack_o && n < 8);
        wbif.wb_cyc_i = 1'b0;
        wbif.wb_stb_i = 1'b0;
        wbif.wb_we_i  = 1'b0;
        cq.push_back('{kind: K_VAL, exp: 32'd1, act: 32'(n), name: {nm, "_lat"}});
    endtask

    task automatic wr(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] sel);
        access(1'b1, idx, d, sel, 1'b0, 32'd0, $sformatf("wr%0d", idx));
    endtask

    task automatic rd(input logic [3:0] idx, input logic [31:0] e, input string nm);
        access(1'b0, idx, 32'd0, 4'h0, 1'b1, e, nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_exp = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_7FFF, 32'h0, 32'h0};
        rst           = 1'b1;
        i_gpio        = '0;
        wbif.wb_cyc_i = 1'b0;
        wbif.wb_stb_i = 1'b0;
        wbif.wb_we_i  = 1'b0;
        wbif.wb_adr_i = '0;
        wbif.wb_dat_i = '0;
        wbif.wb_sel_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        pchk(K_OGPIO, 32'h0, "rst_ogpio");
        pchk(K_EN, 32'hFFFF_FFFF, "rst_en");
        pchk(K_IOSEL, 32'h0000_7FFF, "rst_iosel");
        pchk(K_INTA, 32'h0, "rst_inta");
        for (int i = 0; i < 16; i++) rd(4'(i), rst_exp[i], $sformatf("rst_idx%0d", i));

        // Atomic output writes and byte lanes
        wr(GPIO_OUT, 32'h0000_00F0, 4'hF);
        wr(GPIO_OUT_SET, 32'h0000_000F, 4'b0001);
        wr(GPIO_OUT_CLR, 32'h0000_0030, 4'b0001);
        wr(GPIO_OUT_TGL, 32'h0000_0081, 4'b0001);
        rd(GPIO_OUT, 32'h0000_004E, "out_atomic");
        wr(GPIO_OUT, 32'hFFFF_FFFF, 4'h0);
        wr(GPIO_OUT_SET, 32'h0000_FF00, 4'b0001);
        rd(GPIO_OUT, 32'h0000_004E, "out_sel0");
        rd(GPIO_OUT_CLR, 32'h0000_004E, "clr_reads_out");
        pchk(K_OGPIO, 32'h0000_004E, "ogpio_pins");
        wr(GPIO_OE, 32'h0000_00FF, 4'b0011);
        pchk(K_EN, 32'hFFFF_00FF, "oe_lanes");
        rd(GPIO_DBEN + 4'd3, 32'h0, "unmapped14");

        // Both-edge interrupt on pin 3
        wr(GPIO_IO_SEL, 32'h0, 4'hF);
        wr(GPIO_IE, 32'h8, 4'hF);
        wr(GPIO_IBOTH, 32'h8, 4'hF);
        wr(GPIO_IS, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1 i_gpio[3] = 1'b1;
        repeat (2) @(posedge clk);
        #1 pchk(K_INTA, 32'h0, "rise3_early");
        @(posedge clk);
        #1 pchk(K_INTA, 32'h1, "rise3_inta");
        rd(GPIO_IS, 32'h8, "rise3_is");
        wr(GPIO_IS, 32'h8, 4'hF);
        rd(GPIO_IS, 32'h0, "rise3_w1c");
        @(posedge clk); #1 i_gpio[3] = 1'b0;
        repeat (2) @(posedge clk);
        #1 pchk(K_INTA, 32'h0, "fall3_early");
        @(posedge clk);
        #1 pchk(K_INTA, 32'h1, "fall3_inta");
        rd(GPIO_IS, 32'h8, "fall3_is");
        wr(GPIO_IS, 32'h8, 4'hF);
        rd(GPIO_IS, 32'h0, "fall3_w1c");
        pchk(K_INTA, 32'h0, "fall3_inta_clr");
        // W1C commits on the same edge the new IS bit is set
        @(posedge clk); #1 i_gpio[3] = 1'b1;
        @(posedge clk);
        wr(GPIO_IS, 32'h8, 4'hF);
        rd(GPIO_IS, 32'h8, "set_wins");

        // Low-level interrupt on pin 5
        wr(GPIO_IE, 32'h0, 4'hF);
        wr(GPIO_IS, 32'hFFFF_FFFF, 4'hF);
        wr(GPIO_ITYPE, 32'h20, 4'hF);
        wr(GPIO_IPOL, 32'h20, 4'hF);
        wr(GPIO_IE, 32'h20, 4'hF);
        rd(GPIO_IS, 32'h20, "lvl5_is");
        wr(GPIO_IS, 32'h20, 4'hF);
        rd(GPIO_IS, 32'h20, "lvl5_reassert1");
        wr(GPIO_IS, 32'h20, 4'hF);
        rd(GPIO_IS, 32'h20, "lvl5_reassert2");
        pchk(K_INTA, 32'h1, "lvl5_inta");
        i_gpio[5] = 1'b1;
        repeat (4) @(posedge clk);
        wr(GPIO_IS, 32'h20, 4'hF);
        rd(GPIO_IS, 32'h0, "lvl5_released");
        pchk(K_INTA, 32'h0, "lvl5_inta_off");

        // Debounce on pin 0: 7 ticks of 10 cycles
        wr(GPIO_IE, 32'h0, 4'hF);
        wr(GPIO_ITYPE, 32'h0, 4'hF);
        wr(GPIO_IPOL, 32'h0, 4'hF);
        wr(GPIO_IBOTH, 32'h0, 4'hF);
        wr(GPIO_IS, 32'hFFFF_FFFF, 4'hF);
        wr(GPIO_DBDIV, 32'h00AB_0009, 4'hF);
        rd(GPIO_DBDIV, 32'h0000_0009, "dbdiv_width");
        wr(GPIO_DBEN, 32'h1, 4'hF);
        wr(GPIO_IE, 32'h1, 4'hF);
        @(posedge clk); #1 i_gpio[0] = 1'b1;
        repeat (50) @(posedge clk);
        #1 i_gpio[0] = 1'b0;
        repeat (20) @(posedge clk);
        rd(GPIO_IN, 32'h0000_0028, "db_glitch_in");
        rd(GPIO_IS, 32'h0, "db_glitch_is");
        @(posedge clk); #1 i_gpio[0] = 1'b1;
        repeat (100) @(posedge clk);
        rd(GPIO_IN, 32'h0000_0029, "db_hold_in");
        rd(GPIO_IS, 32'h1, "db_hold_is");
        pchk(K_INTA, 32'h1, "db_inta");
        wr(GPIO_IS, 32'h1, 4'hF);
        repeat (30) @(posedge clk);
        rd(GPIO_IS, 32'h0, "db_once");

        // Pin owned by alternate peripheral never interrupts
        wr(GPIO_IE, 32'h0, 4'hF);
        wr(GPIO_DBEN, 32'h0, 4'hF);
        wr(GPIO_IS, 32'hFFFF_FFFF, 4'hF);
        wr(GPIO_IO_SEL, 32'h4, 4'hF);
        pchk(K_IOSEL, 32'h4, "iosel_pins");
        wr(GPIO_IE, 32'h4, 4'hF);
        @(posedge clk); #1 i_gpio[2] = 1'b1;
        repeat (6) @(posedge clk);
        rd(GPIO_IS, 32'h0, "iosel_is");
        pchk(K_INTA, 32'h0, "iosel_inta");

        // Async reset while a toggle write is being acknowledged
        wr(GPIO_OUT, 32'h55, 4'hF);
        pchk(K_OGPIO, 32'h55, "pre_rst_out");
        @(posedge clk);
        #1;
        wbif.wb_cyc_i = 1'b1;
        wbif.wb_stb_i = 1'b1;
        wbif.wb_we_i  = 1'b1;
        wbif.wb_adr_i = {GPIO_OUT_TGL, 2'b00};
        wbif.wb_dat_i = 32'hFF;
        wbif.wb_sel_i = 4'hF;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        pchk(K_ACK, 32'h0, "midrst_ack");
        pchk(K_OGPIO, 32'h0, "midrst_out");
        @(posedge clk);
        #1;
        wbif.wb_cyc_i = 1'b0;
        wbif.wb_stb_i = 1'b0;
        wbif.wb_we_i  = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        rd(GPIO_OUT, 32'h0, "post_rst_out");
        rd(GPIO_IE, 32'h0, "post_rst_ie");
        rd(GPIO_IO_SEL, 32'h0000_7FFF, "post_rst_iosel");

        repeat (3) @(posedge clk);
        #1 cq.push_back('{kind: K_VAL, exp: 32'd0, act: 32'(rq.size()), name: "leftover_reads"});
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_v2_top.md
Name: gpio_v2_top

Overview:
- Second-generation Wishbone GPIO for the SoC uncore, drop-in successor to the current GPIO block.
- Parametrised pin count and shared-pin mux.
- Adds atomic set/clear/toggle output writes, per-pin interrupt mode (rising, falling, both edges, high level, low level) and a per-pin debounce filter with a programmable prescaler.
- Sits on the peripheral Wishbone bus; wb_inta_o goes to the PLIC/interrupt aggregator.

Parameters:
- NO_OF_GPIO_PINS, 32, number of GPIO pins (1..32).
- NO_OF_SHARED_PINS, 15, pins shared with other peripherals via io_sel (0..NO_OF_GPIO_PINS).
- DB_CNT_W, 3, width of the per-pin stability counter. A pin must be stable for 2^DB_CNT_W-1 prescaler ticks before the filtered value changes.

Ports:
- wb_clk_i  in  1  single clock domain.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  6  byte address; word index = wb_adr_i[5:2].
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte lane select.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  tied 0.
- i_gpio  in  NO_OF_GPIO_PINS  asynchronous pin inputs.
- o_gpio  out  NO_OF_GPIO_PINS  output values.
- en_gpio  out  NO_OF_GPIO_PINS  output enables (1 = drive).
- io_sel  out  NO_OF_SHARED_PINS  1 = pin owned by the alternate peripheral.
- wb_inta_o  out  1  level interrupt.

Behaviour:
- Reset values (async): OUT=0, OE=all 1, IE=0, IS=0, ITYPE=0, IPOL=0, IBOTH=0, DBEN=0, DBDIV=0, IO_SEL=all 1. Synchronisers, filtered state, prev state, counters and wb_ack_o are all 0.
- Bus handshake:
  - wb_acc = cyc & stb.
  - wb_ack_o <= wb_acc & ~wb_ack_o, giving one-cycle latency and one ack per access.
  - A write commits only in the cycle where wb_acc & ~wb_ack_o, so it takes effect exactly once; side-effect registers rely on this.
- Reads: combinational mux on the word index, valid while wb_ack_o=1. Bits above the implemented width read 0. Unmapped indices read 0 and ignore writes.
- Byte lanes: wb_sel_i[k] gates bits [8k+7:8k] of every writable register; bits beyond the implemented width are ignored.
- Register map (word index):
  - 0 IN (RO): filtered input.
  - 1 OUT (RW).
  - 2 OE (RW).
  - 3 OUT_SET (WO): OUT |= data.
  - 4 OUT_CLR (WO): OUT &= ~data.
  - 5 OUT_TGL (WO): OUT ^= data. Indices 3, 4 and 5 read the current OUT.
  - 6 IE (RW).
  - 7 IS (RW1C).
  - 8 ITYPE (RW): 0 = edge, 1 = level.
  - 9 IPOL (RW): 0 = rising/high, 1 = falling/low.
  - 10 IBOTH (RW): 1 = both edges; valid only when ITYPE=0, overrides IPOL.
  - 11 DBEN (RW).
  - 12 DBDIV (RW, bits [15:0]).
  - 13 IO_SEL (RW, bits [NO_OF_SHARED_PINS-1:0]).
- Input path:
  - Two-flop synchroniser gives s[i].
  - DBEN[i]=0: filt[i]=s[i].
  - DBEN[i]=1: the prescaler emits a tick every DBDIV+1 cycles; DBDIV=0 means a tick every cycle.
  - Per-pin counter clears whenever s[i]==filt[i]. Otherwise it increments on each tick. On reaching all-ones, filt[i]<=s[i] and the counter clears.
  - Writing DBDIV restarts the prescaler. Clearing DBEN[i] clears cnt[i].
- Detection:
  - prev <= filt each cycle.
  - rise = filt & ~prev; fall = ~filt & prev.
  - hit[i]:
    - edge mode: IBOTH ? (rise|fall) : (IPOL ? fall : rise).
    - level mode: IPOL ? ~filt : filt.
  - Qualify: qual = hit & IE & ~{IO_SEL-extended-to-pins}. Pins owned by the alternate peripheral never interrupt; OE does not gate interrupts.
- IS update each cycle: IS <= (IS & ~w1c_mask) | qual, where w1c_mask = data & byte-lane mask on a committed write to index 7.
  - Simultaneous set and clear: set wins.
  - Level interrupts re-assert on the cycle after a clear while the level persists.
- wb_inta_o = |(IS & IE), combinational from registers. Clearing IE masks the output without clearing IS.
- Reset asserted mid-transfer: ack drops immediately and no write commits. The master must restart the cycle.

Decomposition:
- gpio_v2_pkg holds:
  - register index localparams (GPIO_IN .. GPIO_IO_SEL);
  - the IRQ mode encoding constants;
  - DBDIV width (16).
- One sub-module, gpio_debounce, holds one pin's filter: inputs s, tick, en; output filt; DB_CNT_W parameter. It is instantiated in a generate loop over NO_OF_GPIO_PINS. The prescaler stays in the top.

Test Plan:
- Reset then read every index:
  - IN=0, OUT=0, OE=0xFFFFFFFF, IO_SEL=0x7FFF, rest 0;
  - each access acks exactly one cycle after stb.
- OUT=0x0000_00F0; write SET 0x0F, CLR 0x30, TGL 0x81 with wb_sel_i=4'b0001 -> OUT=0x4E. A write with sel=0 leaves OUT unchanged.
- IO_SEL=0, IE[3]=1, IBOTH[3]=1; toggle i_gpio[3] 0->1->0:
  - IS[3] sets 3 cycles after each edge and inta asserts;
  - W1C 0x8 clears it;
  - a clear issued in the same cycle as a new edge leaves IS[3]=1.
- ITYPE[5]=1, IPOL[5]=1, IE[5]=1, hold i_gpio[5]=0 -> IS[5] re-sets the cycle after each W1C. Drive the pin to 1 and then clear -> IS[5] stays 0.
- DBEN[0]=1, DBDIV=9, DB_CNT_W=3:
  - a 50-cycle glitch on i_gpio[0] leaves IN[0]=0;
  - holding the pin high for at least 70 cycles plus the synchroniser delay sets IN[0]=1, and a rising edge IRQ fires once.
- IO_SEL[2]=1, IE[2]=1, rising edge on i_gpio[2] -> no IS, no inta. Async reset mid-write to OUT_TGL -> OUT=0 and ack=0 immediately.
